// File: rtl/qsfp_led_ctrlport_target_if.sv
// ControlPort request/response bundle between the FPGA LED initiator and the
// CPLD-side LED register target.
interface qsfp_led_ctrlport_target_if;
    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_byte_en;
    logic        resp_ack;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr, req_data, req_byte_en,
        input  resp_ack, resp_status, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr, req_data, req_byte_en,
        output resp_ack, resp_status, resp_data
    );
endinterface

// File: rtl/qsfp_led_ctrlport_target.sv
// ControlPort target holding the 16-bit QSFP LED word; drives link LEDs steady,
// activity LEDs blinking, and blanks everything if the FPGA stops refreshing.
module qsfp_led_ctrlport_target #(
    parameter logic [19:0] LED_REGISTER_ADDRESS = 20'd0,
    parameter int          BLINK_CYCLES         = 2500000,
    parameter int          WATCHDOG_CYCLES      = 0
) (
    input  logic                         ctrlport_clk,
    input  logic                         ctrlport_rst,
    qsfp_led_ctrlport_target_if.slave    s_ctrlport,
    output logic [3:0]                   qsfp0_led_link,
    output logic [3:0]                   qsfp0_led_active,
    output logic [3:0]                   qsfp1_led_link,
    output logic [3:0]                   qsfp1_led_active,
    output logic                         watchdog_expired
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic        w_hit, w_req, w_wr_acc, w_rd_acc, w_cmderr, w_expired;
    logic        r_ack;
    logic [1:0]  r_status;
    logic [31:0] r_rdata;
    logic [15:0] r_led;
    logic [BW-1:0] r_blink_cnt;
    logic        r_blink_phase;
    logic [3:0]  r_q0_link, r_q0_act, r_q1_link, r_q1_act;

    // Upper data half and upper byte enables carry nothing for a 16-bit register.
    logic w_unused_req_bits;
    assign w_unused_req_bits = &{1'b0, s_ctrlport.req_data[31:16], s_ctrlport.req_byte_en[3:2]};

    assign w_hit    = (s_ctrlport.req_addr == LED_REGISTER_ADDRESS);
    assign w_req    = w_hit & (s_ctrlport.req_wr | s_ctrlport.req_rd);
    assign w_cmderr = w_hit & s_ctrlport.req_wr & s_ctrlport.req_rd;
    assign w_wr_acc = w_hit & s_ctrlport.req_wr & ~s_ctrlport.req_rd;
    assign w_rd_acc = w_hit & s_ctrlport.req_rd & ~s_ctrlport.req_wr;

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_ack    <= 1'b0;
            r_status <= 2'b00;
            r_rdata  <= 32'd0;
        end else begin
            r_ack    <= w_req;
            r_status <= w_cmderr ? 2'b01 : 2'b00;
            r_rdata  <= w_rd_acc ? {16'd0, r_led} : 32'd0;
        end
    end

    assign s_ctrlport.resp_ack    = r_ack;
    assign s_ctrlport.resp_status = r_status;
    assign s_ctrlport.resp_data   = r_rdata;

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_led <= 16'd0;
        end else if (w_wr_acc) begin
            if (s_ctrlport.req_byte_en[0]) r_led[7:0]  <= s_ctrlport.req_data[7:0];
            if (s_ctrlport.req_byte_en[1]) r_led[15:8] <= s_ctrlport.req_data[15:8];
        end
    end

    // Single global phase so every activity LED blinks in unison.
    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    generate
        if (WATCHDOG_CYCLES > 0) begin : g_wd
            localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
            localparam logic [WW-1:0] WD_MAX = WW'(WATCHDOG_CYCLES);
            logic [WW-1:0] r_wd_cnt;

            // A write in the saturation cycle still clears the counter.
            always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
                if (ctrlport_rst)           r_wd_cnt <= '0;
                else if (w_wr_acc)          r_wd_cnt <= '0;
                else if (r_wd_cnt != WD_MAX) r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            assign w_expired = (r_wd_cnt == WD_MAX);
        end else begin : g_no_wd
            assign w_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_q0_link <= 4'd0;
            r_q0_act  <= 4'd0;
            r_q1_link <= 4'd0;
            r_q1_act  <= 4'd0;
        end else begin
            r_q0_link <= r_led[3:0]   & {4{~w_expired}};
            r_q0_act  <= r_led[7:4]   & {4{r_blink_phase & ~w_expired}};
            r_q1_link <= r_led[11:8]  & {4{~w_expired}};
            r_q1_act  <= r_led[15:12] & {4{r_blink_phase & ~w_expired}};
        end
    end

    assign qsfp0_led_link   = r_q0_link;
    assign qsfp0_led_active = r_q0_act;
    assign qsfp1_led_link   = r_q1_link;
    assign qsfp1_led_active = r_q1_act;
    assign watchdog_expired = w_expired;

endmodule

// File: tb/tb_qsfp_led_ctrlport_target.sv
// Scoreboard bench for the QSFP LED ControlPort target: directed scenarios then
// randomized traffic, checked against a cycle-count reference model.
module tb_qsfp_led_ctrlport_target;

    localparam logic [19:0] ADDR  = 20'h00012;
    localparam int          BLINK = 4;
    localparam int          WD    = 8;

    logic ctrlport_clk = 1'b0;
    logic ctrlport_rst = 1'b0;
    always #5 ctrlport_clk = ~ctrlport_clk;

    qsfp_led_ctrlport_target_if bus ();
    logic [3:0] q0_link, q0_act, q1_link, q1_act;
    logic       wd_exp;

    qsfp_led_ctrlport_target #(
        .LED_REGISTER_ADDRESS (ADDR),
        .BLINK_CYCLES         (BLINK),
        .WATCHDOG_CYCLES      (WD)
    ) dut (
        .ctrlport_clk     (ctrlport_clk),
        .ctrlport_rst     (ctrlport_rst),
        .s_ctrlport       (bus.slave),
        .qsfp0_led_link   (q0_link),
        .qsfp0_led_active (q0_act),
        .qsfp1_led_link   (q1_link),
        .qsfp1_led_active (q1_act),
        .watchdog_expired (wd_exp)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: register contents, edges since reset, cycles since last write.
    typedef struct {
        logic [1:0]  st;
        logic [31:0] data;
        longint      due;
    } resp_t;
    resp_t       sb[$];
    logic [15:0] m_reg  = 16'd0;
    longint      m_n    = 0;
    int          m_idle = 0;
    logic [7:0]  e_link = 8'd0;
    logic [7:0]  e_act  = 8'd0;

    initial begin
        forever begin
            @(posedge ctrlport_clk or posedge ctrlport_rst);
            if (ctrlport_rst) begin
                m_reg = 16'd0; m_n = 0; m_idle = 0; e_link = 8'd0; e_act = 8'd0;
                sb.delete();
            end else begin
                automatic logic  expired = (m_idle == WD);
                automatic logic  phase   = ((m_n / BLINK) % 2) == 0;
                automatic logic  wr      = bus.req_wr;
                automatic logic  rd      = bus.req_rd;
                automatic logic  hit     = (bus.req_addr == ADDR) && (wr || rd);
                automatic resp_t r;
                if (hit) begin
                    r.st   = (wr && rd) ? 2'b01 : 2'b00;
                    r.data = (rd && !wr) ? {16'd0, m_reg} : 32'd0;
                    r.due  = m_n + 1;
                    sb.push_back(r);
                end
                e_link = expired ? 8'd0 : {m_reg[11:8], m_reg[3:0]};
                e_act  = (expired || !phase) ? 8'd0 : {m_reg[15:12], m_reg[7:4]};
                if (hit && wr && !rd) begin
                    if (bus.req_byte_en[0]) m_reg[7:0]  = bus.req_data[7:0];
                    if (bus.req_byte_en[1]) m_reg[15:8] = bus.req_data[15:8];
                    m_idle = 0;
                end else if (m_idle < WD) begin
                    m_idle++;
                end
                m_n++;
            end
        end
    end

    // Monitor: LEDs every cycle, responses popped from the scoreboard on ack.
    initial begin
        forever begin
            @(negedge ctrlport_clk);
            check("led_link",   {24'd0, q1_link, q0_link}, {24'd0, e_link});
            check("led_active", {24'd0, q1_act, q0_act},   {24'd0, e_act});
            check("wd_expired", {31'd0, wd_exp}, {31'd0, (m_idle == WD)});
            if (bus.resp_ack) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_ack: got ack=1 expected ack=0 at %0t", $time);
                end else begin
                    automatic resp_t r = sb.pop_front();
                    check("ack_latency", 32'(m_n), 32'(r.due));
                    check("resp_status", {30'd0, bus.resp_status}, {30'd0, r.st});
                    check("resp_data",   bus.resp_data, r.data);
                end
            end else begin
                check("idle_status", {30'd0, bus.resp_status}, 32'd0);
                check("idle_data",   bus.resp_data, 32'd0);
                if (sb.size() > 0 && sb[0].due <= m_n) begin
                    n_total++;
                    $display("FAIL missing_ack: got ack=0 expected ack=1 at %0t", $time);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic wr, input logic rd, input logic [19:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        @(posedge ctrlport_clk); #1;
        bus.req_wr = wr; bus.req_rd = rd; bus.req_addr = addr;
        bus.req_data = data; bus.req_byte_en = be;
        @(posedge ctrlport_clk); #1;
        bus.req_wr = 1'b0; bus.req_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ctrlport_clk);
    endtask

    initial begin
        bus.req_wr = 1'b0; bus.req_rd = 1'b0; bus.req_addr = 20'd0;
        bus.req_data = 32'd0; bus.req_byte_en = 4'd0;
        #1 ctrlport_rst = 1'b1;
        #1;
        check("rst_ack",   {31'd0, bus.resp_ack}, 32'd0);
        check("rst_leds",  {16'd0, q1_act, q1_link, q0_act, q0_link}, 32'd0);
        check("rst_wd",    {31'd0, wd_exp}, 32'd0);
        idle(3); #1 ctrlport_rst = 1'b0;

        // Link/blink: refresh often enough that the watchdog stays quiet.
        repeat (3) begin
            drive(1'b1, 1'b0, ADDR, 32'h0000_F00F, 4'b0011);
            idle(4);
        end

        // Byte-lane write then readback of merged value.
        drive(1'b1, 1'b0, ADDR, 32'h0000_00FF, 4'b0011);
        drive(1'b1, 1'b0, ADDR, 32'h0000_A5A5, 4'b0010);
        drive(1'b0, 1'b1, ADDR, 32'd0, 4'b0000);

        // Neighbouring address belongs to someone else.
        drive(1'b1, 1'b0, ADDR + 20'd1, 32'h0000_1234, 4'b0011);
        drive(1'b0, 1'b1, ADDR + 20'd1, 32'd0, 4'b0000);
        idle(10);
        drive(1'b0, 1'b1, ADDR, 32'd0, 4'b0000);

        // Simultaneous wr/rd, then no-op write with byte_en=0.
        drive(1'b1, 1'b1, ADDR, 32'h0000_0000, 4'b0011);
        drive(1'b1, 1'b0, ADDR, 32'h0000_0000, 4'b0000);
        drive(1'b0, 1'b1, ADDR, 32'd0, 4'b0000);

        // Watchdog expiry and recovery.
        drive(1'b1, 1'b0, ADDR, 32'h0000_FFFF, 4'b0011);
        idle(12);
        check("wd_after_idle", {31'd0, wd_exp}, 32'd1);
        drive(1'b1, 1'b0, ADDR, 32'h0000_FFFF, 4'b0000);
        idle(2);
        check("wd_recovered", {31'd0, wd_exp}, 32'd0);

        // Reset while an ack is on the bus and LEDs are lit.
        drive(1'b1, 1'b0, ADDR, 32'h0000_FFFF, 4'b0011);
        idle(2); #1;
        bus.req_wr = 1'b1; bus.req_addr = ADDR; bus.req_data = 32'h0000_0F0F; bus.req_byte_en = 4'b0011;
        @(posedge ctrlport_clk); #1;
        bus.req_wr = 1'b0;
        ctrlport_rst = 1'b1;
        #1;
        check("midrst_ack",  {31'd0, bus.resp_ack}, 32'd0);
        check("midrst_leds", {16'd0, q1_act, q1_link, q0_act, q0_link}, 32'd0);
        idle(2); #1 ctrlport_rst = 1'b0;
        idle(3);
        drive(1'b0, 1'b1, ADDR, 32'd0, 4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            automatic int          sel  = int'($urandom_range(0, 9));
            automatic logic [31:0] d    = $urandom;
            automatic logic [3:0]  be   = 4'($urandom);
            automatic logic [19:0] addr = 20'($urandom);
            if (addr == ADDR) addr = ADDR ^ 20'h1;
            case (sel)
                0, 1, 2, 3: drive(1'b1, 1'b0, ADDR, d, be);
                4, 5:       drive(1'b0, 1'b1, ADDR, d, be);
                6:          drive(1'b1, 1'b1, ADDR, d, be);
                7:          drive(sel[0], ~sel[0], addr, d, be);
                default:    idle(int'($urandom_range(0, 12)));
            endcase
        end

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
